// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: request, response and ALU-side signals of the ALU issue arbiter
interface alu_issue_arbiter_if #(parameter int DSIZE = 32);
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]       req0_code, req1_code;
   logic [DSIZE-1:0] req0_a, req0_b, req0_imm;
   logic [DSIZE-1:0] req1_a, req1_b, req1_imm;
   logic             rsp0_valid, rsp1_valid, rsp_zero;
   logic [DSIZE-1:0] rsp_out;
   logic [3:0]       alu_code;
   logic [DSIZE-1:0] alu_a, alu_b, alu_imm, alu_out;
   logic             alu_zero, busy;
   modport slave (
      input  req0_valid, req0_code, req0_a, req0_b, req0_imm,
      input  req1_valid, req1_code, req1_a, req1_b, req1_imm,
      input  alu_out, alu_zero,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out, rsp_zero,
      output alu_code, alu_a, alu_b, alu_imm, busy
   );
   modport master (
      output req0_valid, req0_code, req0_a, req0_b, req0_imm,
      output req1_valid, req1_code, req1_a, req1_b, req1_imm,
      output alu_out, alu_zero,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out, rsp_zero,
      input  alu_code, alu_a, alu_b, alu_imm, busy
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin sharing of one registered ALU between two requesters
module alu_issue_arbiter #(
   parameter int         DSIZE   = 32,
   parameter int         MUL_LAT = 3,
   parameter logic [3:0] OP_ADD  = 4'h0,
   parameter logic [3:0] OP_MUL  = 4'h1
) (
   input logic               clk,
   input logic               rst,
   alu_issue_arbiter_if.slave io_bus
);
   localparam int CW = $clog2(MUL_LAT + 1);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_owner, r_last_grant, r_rsp0, r_rsp1;
   logic [3:0]       r_code;
   logic [DSIZE-1:0] r_a, r_b, r_imm;
   logic             w_can_accept, w_grant0, w_grant1, w_accept;
   logic [3:0]       w_code;
   logic [DSIZE-1:0] w_a, w_b, w_imm;
   // on a tie the requester that did not win last time gets the ALU
   assign w_can_accept = (r_state != EXEC);
   assign w_grant1     = io_bus.req1_valid & (~io_bus.req0_valid | ~r_last_grant);
   assign w_grant0     = io_bus.req0_valid & ~w_grant1;
   assign w_accept     = w_can_accept & (w_grant0 | w_grant1);
   assign w_code       = w_grant1 ? io_bus.req1_code : io_bus.req0_code;
   assign w_a          = w_grant1 ? io_bus.req1_a    : io_bus.req0_a;
   assign w_b          = w_grant1 ? io_bus.req1_b    : io_bus.req0_b;
   assign w_imm        = w_grant1 ? io_bus.req1_imm  : io_bus.req0_imm;
   assign io_bus.req0_ready = w_can_accept & w_grant0;
   assign io_bus.req1_ready = w_can_accept & w_grant1;
   assign io_bus.rsp0_valid = r_rsp0;
   assign io_bus.rsp1_valid = r_rsp1;
   assign io_bus.rsp_out    = io_bus.alu_out;
   assign io_bus.rsp_zero   = io_bus.alu_zero;
   assign io_bus.alu_code   = r_code;
   assign io_bus.alu_a      = r_a;
   assign io_bus.alu_b      = r_b;
   assign io_bus.alu_imm    = r_imm;
   assign io_bus.busy       = (r_state != IDLE);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_rsp0       <= 1'b0;
         r_rsp1       <= 1'b0;
         r_code       <= OP_ADD;
         r_a          <= '0;
         r_b          <= '0;
         r_imm        <= '0;
      end else begin
         r_rsp0 <= 1'b0;
         r_rsp1 <= 1'b0;
         if (w_accept) begin
            r_state      <= EXEC;
            r_code       <= w_code;
            r_a          <= w_a;
            r_b          <= w_b;
            r_imm        <= w_imm;
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
            r_cnt        <= (w_code == OP_MUL) ? CW'(MUL_LAT) : CW'(1);
         end else if (r_state == EXEC) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_state <= RESP;
               r_rsp0  <= ~r_owner;
               r_rsp1  <= r_owner;
            end
         end else if (r_state == RESP) begin
            r_state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed steps with a response scoreboard and a behavioural registered ALU
module tb_alu_issue_arbiter;
   localparam logic [3:0] ADD = 4'h0, MUL = 4'h1, ADDI = 4'h2, LW = 4'h3, SW = 4'h4, BNE = 4'h5, UND = 4'hF;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   alu_issue_arbiter_if #(.DSIZE(32)) bus();
   alu_issue_arbiter #(.DSIZE(32), .MUL_LAT(3), .OP_ADD(ADD), .OP_MUL(MUL)) dut (
      .clk(clk), .rst(rst), .io_bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {logic owner; logic [32:0] r;} exp_t;
   exp_t        sb[$];
   exp_t        e_mon;
   logic [32:0] sb_last = '0;
   logic [32:0] alu_q = '0;
   function automatic logic [32:0] alu_ref(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [32:0] prev);
      logic [31:0] r;
      case (c)
         ADD:         r = a + b;
         MUL:         r = a * b;
         ADDI, LW, SW: r = a + imm;
         BNE:         r = a - b;
         default:     return prev;
      endcase
      return {r == 32'd0, r};
   endfunction
   // registered ALU: result appears on the edge after its operands are presented
   always @(posedge clk) alu_q <= alu_ref(bus.alu_code, bus.alu_a, bus.alu_b, bus.alu_imm, alu_q);
   assign bus.alu_out  = alu_q[31:0];
   assign bus.alu_zero = alu_q[32];
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic drv(int n, logic v, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_code = c; bus.req0_a = a; bus.req0_b = b; bus.req0_imm = imm;
      end else begin
         bus.req1_valid = v; bus.req1_code = c; bus.req1_a = a; bus.req1_b = b; bus.req1_imm = imm;
      end
   endtask
   always @(negedge clk) begin
      if (rst) sb.delete();
      else begin
         if (bus.rsp0_valid | bus.rsp1_valid) begin
            chk("sb_one_rsp", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
            chk("sb_pending", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
               e_mon = sb.pop_front();
               chk("sb_owner", {31'd0, bus.rsp1_valid}, {31'd0, e_mon.owner});
               chk("sb_out", bus.rsp_out, e_mon.r[31:0]);
               chk("sb_zero", {31'd0, bus.rsp_zero}, {31'd0, e_mon.r[32]});
            end
         end
         if (bus.req0_valid && bus.req0_ready) begin
            sb_last = alu_ref(bus.req0_code, bus.req0_a, bus.req0_b, bus.req0_imm, sb_last);
            sb.push_back('{1'b0, sb_last});
         end
         if (bus.req1_valid && bus.req1_ready) begin
            sb_last = alu_ref(bus.req1_code, bus.req1_a, bus.req1_b, bus.req1_imm, sb_last);
            sb.push_back('{1'b1, sb_last});
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      drv(0, 0, ADD, 0, 0, 0);
      drv(1, 0, ADD, 0, 0, 0);
      nxt(); nxt(); #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
      chk("rst_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
      chk("rst_code", {28'd0, bus.alu_code}, {28'd0, ADD});
      chk("rst_a", bus.alu_a, 32'd0);
      chk("rst_b", bus.alu_b, 32'd0);
      chk("rst_imm", bus.alu_imm, 32'd0);
      rst = 1'b0;
      // single ADD from req0
      nxt(); drv(0, 1, ADD, 5, 7, 0); #1;
      chk("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
      chk("t1_ready1", {31'd0, bus.req1_ready}, 32'd0);
      nxt(); drv(0, 0, ADD, 0, 0, 0); #1;
      chk("t1_busy", {31'd0, bus.busy}, 32'd1);
      chk("t1_alu_a", bus.alu_a, 32'd5);
      chk("t1_alu_b", bus.alu_b, 32'd7);
      chk("t1_rsp0_early", {31'd0, bus.rsp0_valid}, 32'd0);
      nxt(); #1;
      chk("t1_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t1_out", bus.rsp_out, 32'd12);
      chk("t1_zero", {31'd0, bus.rsp_zero}, 32'd0);
      nxt(); #1;
      chk("t1_idle", {31'd0, bus.busy}, 32'd0);
      chk("t1_rsp0_off", {31'd0, bus.rsp0_valid}, 32'd0);
      // MUL from req1 while req0 waits behind it
      nxt(); drv(1, 1, MUL, 6, 7, 0); #1;
      chk("t2_ready1", {31'd0, bus.req1_ready}, 32'd1);
      nxt(); drv(1, 0, ADD, 0, 0, 0); drv(0, 1, ADD, 2, 3, 0); #1;
      chk("t2_code", {28'd0, bus.alu_code}, {28'd0, MUL});
      for (int i = 0; i < 3; i++) begin
         if (i > 0) nxt();
         #1;
         chk("t2_ready0_exec", {31'd0, bus.req0_ready}, 32'd0);
         chk("t2_ready1_exec", {31'd0, bus.req1_ready}, 32'd0);
         chk("t2_rsp1_early", {31'd0, bus.rsp1_valid}, 32'd0);
      end
      nxt(); #1;
      chk("t2_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("t2_out", bus.rsp_out, 32'd42);
      chk("t2_zero", {31'd0, bus.rsp_zero}, 32'd0);
      chk("t2_ready0_resp", {31'd0, bus.req0_ready}, 32'd1);
      nxt(); drv(0, 0, ADD, 0, 0, 0); #1;
      chk("t2_rsp1_off", {31'd0, bus.rsp1_valid}, 32'd0);
      chk("t2_busy", {31'd0, bus.busy}, 32'd1);
      nxt(); #1;
      chk("t2_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t2_out0", bus.rsp_out, 32'd5);
      nxt(); #1;
      chk("t2_idle", {31'd0, bus.busy}, 32'd0);
      // req1 alone, four back-to-back SW ops
      for (int i = 0; i < 4; i++) begin
         nxt(); drv(1, 1, SW, 32'(100 * i + 1), 32'd0, 32'(i)); #1;
         chk("t6_ready1", {31'd0, bus.req1_ready}, 32'd1);
         if (i > 0) begin
            chk("t6_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
            chk("t6_out", bus.rsp_out, 32'(101 * (i - 1) + 1));
         end
         nxt(); #1;
         chk("t6_ready1_exec", {31'd0, bus.req1_ready}, 32'd0);
      end
      drv(1, 0, ADD, 0, 0, 0);
      nxt(); #1;
      chk("t6_rsp1_last", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("t6_out_last", bus.rsp_out, 32'd304);
      nxt(); #1;
      chk("t6_idle", {31'd0, bus.busy}, 32'd0);
      // both valid continuously: grants alternate 0,1,0
      nxt(); drv(0, 1, ADDI, 1, 0, 2); drv(1, 1, BNE, 9, 9, 0); #1;
      chk("t3_g0_r0", {31'd0, bus.req0_ready}, 32'd1);
      chk("t3_g0_r1", {31'd0, bus.req1_ready}, 32'd0);
      nxt(); #1;
      chk("t3_exec_r0", {31'd0, bus.req0_ready}, 32'd0);
      chk("t3_exec_r1", {31'd0, bus.req1_ready}, 32'd0);
      nxt(); #1;
      chk("t3_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t3_out0", bus.rsp_out, 32'd3);
      chk("t3_zero0", {31'd0, bus.rsp_zero}, 32'd0);
      chk("t3_g1_r1", {31'd0, bus.req1_ready}, 32'd1);
      chk("t3_g1_r0", {31'd0, bus.req0_ready}, 32'd0);
      nxt(); #1;
      chk("t3_exec2_r0", {31'd0, bus.req0_ready}, 32'd0);
      nxt(); #1;
      chk("t3_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("t3_out1", bus.rsp_out, 32'd0);
      chk("t3_zero1", {31'd0, bus.rsp_zero}, 32'd1);
      chk("t3_g2_r0", {31'd0, bus.req0_ready}, 32'd1);
      nxt(); drv(0, 0, ADD, 0, 0, 0); drv(1, 0, ADD, 0, 0, 0); #1;
      nxt(); #1;
      chk("t3_rsp0b", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t3_out0b", bus.rsp_out, 32'd3);
      nxt();
      // LW address wraps to zero
      nxt(); drv(0, 1, LW, 32'hFFFF_FFF0, 32'd0, 32'h10); #1;
      chk("t4_ready0", {31'd0, bus.req0_ready}, 32'd1);
      nxt(); drv(0, 0, ADD, 0, 0, 0); #1;
      nxt(); #1;
      chk("t4_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t4_out", bus.rsp_out, 32'd0);
      chk("t4_zero", {31'd0, bus.rsp_zero}, 32'd1);
      // undefined opcode: latency 1, previous result returned
      nxt(); drv(1, 1, UND, 123, 456, 789); #1;
      chk("tu_ready1", {31'd0, bus.req1_ready}, 32'd1);
      nxt(); drv(1, 0, ADD, 0, 0, 0); #1;
      nxt(); #1;
      chk("tu_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("tu_out", bus.rsp_out, 32'd0);
      chk("tu_zero", {31'd0, bus.rsp_zero}, 32'd1);
      // reset in the middle of a MUL from req0
      nxt(); drv(0, 1, MUL, 3, 4, 0); #1;
      chk("t5_ready0", {31'd0, bus.req0_ready}, 32'd1);
      nxt(); drv(0, 0, ADD, 0, 0, 0); #1;
      chk("t5_busy", {31'd0, bus.busy}, 32'd1);
      nxt(); rst = 1'b1; #1;
      nxt(); rst = 1'b0; #1;
      chk("t5_busy_rst", {31'd0, bus.busy}, 32'd0);
      chk("t5_rsp0_rst", {31'd0, bus.rsp0_valid}, 32'd0);
      chk("t5_code_rst", {28'd0, bus.alu_code}, {28'd0, ADD});
      chk("t5_a_rst", bus.alu_a, 32'd0);
      nxt(); #1;
      chk("t5_no_rsp", {31'd0, bus.rsp0_valid | bus.rsp1_valid}, 32'd0);
      drv(0, 1, ADD, 1, 2, 0); drv(1, 1, ADD, 3, 4, 0); #1;
      chk("t5_tie_r0", {31'd0, bus.req0_ready}, 32'd1);
      chk("t5_tie_r1", {31'd0, bus.req1_ready}, 32'd0);
      nxt(); drv(0, 0, ADD, 0, 0, 0); #1;
      chk("t5_exec_r1", {31'd0, bus.req1_ready}, 32'd0);
      nxt(); #1;
      chk("t5_rsp0", {31'd0, bus.rsp0_valid}, 32'd1);
      chk("t5_out0", bus.rsp_out, 32'd3);
      chk("t5_r1", {31'd0, bus.req1_ready}, 32'd1);
      nxt(); drv(1, 0, ADD, 0, 0, 0); #1;
      nxt(); #1;
      chk("t5_rsp1", {31'd0, bus.rsp1_valid}, 32'd1);
      chk("t5_out1", bus.rsp_out, 32'd7);
      nxt(); #1;
      chk("end_idle", {31'd0, bus.busy}, 32'd0);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
